diff_sequencer: RTL and testbench
=================================

# diff_sequencer

Controller that sequences a single-channel first-difference datapath (out = current sample − previous sample) inside the DSP chain. It accepts samples over a valid/ready handshake and drives the datapath's `hold` and `reset` controls so that its sample buffer advances only on accepted samples. It discards the priming output and registers results onto a valid/ready output stream with backpressure. It sits between the sample source (ADC or FIR stage) and downstream consumers.

## Interface
- `WORD_SIZE`, default 8: sample and difference width, in bits.
- `CNT_WIDTH`, default 16: width of the emitted-difference counter.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: run request; level-sensitive.
- `in_valid`  in  1: source sample valid.
- `in_ready`  out  1: sequencer accepts `in_data` this cycle.
- `in_data`  in  WORD_SIZE: source sample.
- `out_valid`  out  1: `out_data` holds a difference.
- `out_ready`  in  1: consumer accepts `out_data`.
- `out_data`  out  WORD_SIZE: registered difference.
- `diff_data_in`  out  WORD_SIZE: to the datapath's `Data_in`; always equals `in_data`.
- `diff_data_out`  in  WORD_SIZE: from the datapath's `Data_out` (combinational `Data_in − buffer`).
- `diff_hold`  out  1: to the datapath's `hold`.
- `diff_reset`  out  1: to the datapath's `reset`.
- `busy`  out  1: high whenever the state is not IDLE.
- `diff_count`  out  CNT_WIDTH: number of differences emitted.
- `ovf`  out  1: sticky signed-overflow flag (see Configuration).

## Operation
- The datapath buffer loads `in_data` on a clock edge when `diff_hold` = 0 and `diff_reset` = 0.
- `accept` is defined as `in_valid & in_ready`.
- `diff_hold` = ~`accept` in PRIME and RUN, and 1 in every other state.
- States and transitions:
  - IDLE: `in_ready` = 0. When `enable` = 1, go to FLUSH.
  - FLUSH: `diff_reset` = 1 for exactly one cycle, then go to PRIME.
  - PRIME: `in_ready` = 1. On `accept`, the buffer loads the first sample, no output is produced, and the state goes to RUN. If `enable` = 0 and there is no accept, go to IDLE.
  - RUN: `in_ready` = `enable` & (~`out_valid` | `out_ready`). On `accept`:
    - `out_data` ← `diff_data_out`;
    - `out_valid` ← 1;
    - `diff_count` increments.
  - RUN exit: when `enable` = 0, the state goes to DRAIN.
  - DRAIN: `in_ready` = 0. Once `out_valid` = 0, or the pending word is taken (`out_valid & out_ready`), go to IDLE.
- Output handshake:
  - `out_valid` falls on `out_valid & out_ready` unless a new accept occurs in the same cycle.
  - While `out_valid` = 1 and `out_ready` = 0, `out_data` is stable.
- Arithmetic: the difference is modulo 2^WORD_SIZE, computed by the datapath. The sequencer never alters it.
- `diff_count` wraps from 2^CNT_WIDTH−1 to 0. It clears only on `reset`; FLUSH does not clear it.
- A new run (IDLE→FLUSH) always re-primes, so the first sample of each run yields no output.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready` = 0, `out_valid` = 0, `out_data` = 0;
  - `diff_hold` = 1, `diff_reset` = 0;
  - `busy` = 0, `diff_count` = 0, `ovf` = 0.
- Reset mid-operation: a pending output is discarded and the state goes to IDLE.
- Latency: 1 cycle, from an accept edge to `out_valid`.
- Throughput: 1 sample per cycle in RUN while `out_ready` = 1.
- `enable` rising in IDLE: FLUSH occurs on the next cycle and PRIME on the one after. The earliest `in_ready` is therefore 2 cycles after `enable` is sampled high.
- Simultaneous `out_ready` and accept in RUN: the old word is taken and the new word is loaded on the same edge, with no bubble.
- `enable` dropping on the same cycle as an accept in RUN: `in_ready` is already 0 in that cycle, so no accept occurs.
- `diff_reset` is never high in the same cycle as `diff_hold` = 0.

## Configuration
- Macro: `DIFF_SEQ_OVF_EN`.
- Defined:
  - The sequencer keeps a shadow register of the last accepted sample (cleared in FLUSH, loaded on every accept).
  - In RUN, on each accept, `ovf` is set when the signed subtraction `in_data − shadow` overflows: the operands have different signs and the result sign differs from `in_data`'s sign.
  - `ovf` is sticky and clears on `reset` or FLUSH.
- Undefined: no shadow register is built and `ovf` is tied to 0.

## Test plan
- **Basic stream:** reset, `enable` = 1, samples 10, 15, 12 with `out_ready` = 1 → outputs 5, 0xFD; `diff_count` = 2; first sample produces no output.
- **Backpressure:** samples 3, 7, 20 with `out_ready` = 0 after the first output → `out_valid` stays 1, `out_data` holds 4, `in_ready` = 0. Release `out_ready` → next output is 13; no sample is lost.
- **Idle gaps:** `in_valid` toggling 1,0,0,1 with samples 100 then 130 → `diff_hold` = 1 during the gaps; output is 30.
- **Stop/restart:** `enable` drops with an output pending → DRAIN until it is taken, then IDLE. Re-enable with samples 50, 60 → one FLUSH pulse, 50 is discarded, output is 10, `diff_count` continues from its previous value.
- **Reset mid-run:** `reset` asserted while `out_valid` = 1 → next cycle all outputs are at their reset values.
- **Overflow (`DIFF_SEQ_OVF_EN`):** WORD_SIZE = 8, samples 0x7F then 0x80 → `out_data` = 0x01, `ovf` = 1 and stays set. Without the macro → `ovf` = 0.

Source files
------------

// File: rtl/diff_sequencer.sv
// rtl/diff_sequencer.sv - sequencer for a single-channel first-difference datapath
//
// Accepts samples on a valid/ready input stream and drives the external
// difference datapath's hold/reset so its sample buffer advances only on
// accepted samples. The first sample of every run only primes the buffer;
// every later accepted sample produces one registered difference on the
// output stream, which supports backpressure.
//
// Optional feature: define DIFF_SEQ_OVF_EN to build the signed-overflow
// monitor (shadow register + sticky ovf). Without it ovf is tied to 0.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   enable             level-sensitive run request
//   in_valid/in_ready  input sample handshake, in_data sample
//   out_valid/out_ready output difference handshake, out_data difference
//   diff_data_in       to datapath Data_in (mirrors in_data)
//   diff_data_out      from datapath Data_out (Data_in - buffer)
//   diff_hold          to datapath hold (buffer loads when 0)
//   diff_reset         to datapath reset (one-cycle pulse in FLUSH)
//   busy               state is not IDLE
//   diff_count         number of differences emitted (wraps)
//   ovf                sticky signed-overflow flag

module diff_sequencer #(
  parameter int WORD_SIZE = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [WORD_SIZE-1:0] diff_data_in,
  input  logic [WORD_SIZE-1:0] diff_data_out,
  output logic                 diff_hold,
  output logic                 diff_reset,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] diff_count,
  output logic                 ovf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  logic   accept;

  // in_ready depends on out_ready in RUN so a word can be taken and replaced
  // on the same edge without a bubble; it therefore cannot be registered.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      PRIME:   in_ready = 1'b1;
      RUN:     in_ready = enable & (~out_valid | out_ready);
      default: in_ready = 1'b0;
    endcase
  end

  assign accept       = in_valid & in_ready;
  assign diff_data_in = in_data;
  // The buffer moves only on an accepted sample; FLUSH holds it while the
  // datapath reset clears it, so hold=0 and reset=1 never coincide.
  assign diff_hold    = ((state == PRIME) || (state == RUN)) ? ~accept : 1'b1;
  assign diff_reset   = (state == FLUSH);
  assign busy         = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      diff_count <= '0;
    end else begin
      // Output register: a new difference wins over the consumer taking the
      // old one, which gives back-to-back throughput.
      if ((state == RUN) && accept) begin
        out_data   <= diff_data_out;
        out_valid  <= 1'b1;
        diff_count <= diff_count + CNT_ONE;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable) state <= FLUSH;
        end
        FLUSH: begin
          state <= PRIME;
        end
        PRIME: begin
          if (accept)       state <= RUN;
          else if (!enable) state <= IDLE;
        end
        RUN: begin
          // in_ready already carries enable, so no accept can race this exit.
          if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          if (!out_valid || out_ready) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DIFF_SEQ_OVF_EN
  logic [WORD_SIZE-1:0] shadow;
  logic [WORD_SIZE-1:0] shadow_diff;

  // Recomputed locally so the flag does not depend on the datapath timing.
  assign shadow_diff = in_data - shadow;

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= '0;
      ovf    <= 1'b0;
    end else if (state == FLUSH) begin
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) shadow <= in_data;
      // Signed overflow: operands of opposite sign and result sign differs
      // from the minuend.
      if ((state == RUN) && accept &&
          (in_data[WORD_SIZE-1] != shadow[WORD_SIZE-1]) &&
          (shadow_diff[WORD_SIZE-1] != in_data[WORD_SIZE-1])) begin
        ovf <= 1'b1;
      end
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_diff_sequencer.sv
// tb/tb_diff_sequencer.sv - self-checking bench for diff_sequencer

module tb_diff_sequencer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  diff_data_in;
  logic [7:0]  diff_data_out;
  logic        diff_hold;
  logic        diff_reset;
  logic        busy;
  logic [15:0] diff_count;
  logic        ovf;

`ifdef DIFF_SEQ_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  diff_sequencer #(.WORD_SIZE(8), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .diff_data_in(diff_data_in), .diff_data_out(diff_data_out),
    .diff_hold(diff_hold), .diff_reset(diff_reset), .busy(busy),
    .diff_count(diff_count), .ovf(ovf)
  );

  // External first-difference datapath.
  logic [7:0] dp_buf;
  always @(posedge clock) begin
    if (diff_reset)      dp_buf <= 8'd0;
    else if (!diff_hold) dp_buf <= diff_data_in;
  end
  assign diff_data_out = diff_data_in - dp_buf;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: expected differences pushed on accept, popped on handshake.
  logic [7:0] sb_q[$];
  logic [7:0] m_prev   = 8'd0;
  logic       m_primed = 1'b0;
  int         n_pushed = 0;

  always @(negedge clock) begin
    logic [7:0] exp_d;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got %0h expected no output", out_data);
        end else begin
          exp_d = sb_q.pop_front();
          check("sb_out_data", {24'd0, out_data}, {24'd0, exp_d});
        end
      end
      if (in_valid && in_ready) begin
        if (m_primed) begin
          exp_d = in_data - m_prev;
          sb_q.push_back(exp_d);
          n_pushed++;
        end
        m_prev   = in_data;
        m_primed = 1'b1;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    check({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    check({tag, "_out_data"},   {24'd0, out_data},   32'd0);
    check({tag, "_diff_hold"},  {31'd0, diff_hold},  32'd1);
    check({tag, "_diff_reset"}, {31'd0, diff_reset}, 32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_diff_count"}, {16'd0, diff_count}, 32'd0);
    check({tag, "_ovf"},        {31'd0, ovf},        32'd0);
  endtask

  // IDLE -> FLUSH -> PRIME, checking the single diff_reset pulse.
  task automatic start_run;
    enable   = 1'b1;
    m_primed = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    check("flush_diff_reset", {31'd0, diff_reset}, 32'd1);
    check("flush_diff_hold", {31'd0, diff_hold}, 32'd1);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd1);
    tick;
    check("prime_diff_reset", {31'd0, diff_reset}, 32'd0);
    check("prime_in_ready", {31'd0, in_ready}, 32'd1);
    check("prime_ovf", {31'd0, ovf}, 32'd0);
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       ordy;
    logic       exp_ir;
    logic       exp_hold;
    logic       exp_ov;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic stream 10,15,12; backpressure; idle gaps 100 -> 130.
    tbl[0]  = '{1'b1, 8'd10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'd15,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05};
    tbl[2]  = '{1'b1, 8'd12,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFD};
    tbl[3]  = '{1'b1, 8'd3,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hF7};
    tbl[4]  = '{1'b1, 8'd7,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04};
    tbl[5]  = '{1'b1, 8'd20,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04};
    tbl[6]  = '{1'b1, 8'd20,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04};
    tbl[7]  = '{1'b1, 8'd20,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0D};
    tbl[8]  = '{1'b1, 8'd100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h50};
    tbl[9]  = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 8'd130, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1E};
    tbl[12] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    reset     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    tick;
    tick;
    check_reset_values("reset");
    reset = 1'b0;

    start_run;
    for (int i = 0; i < 13; i++) begin
      in_valid  = tbl[i].vld;
      in_data   = tbl[i].data;
      out_ready = tbl[i].ordy;
      @(negedge clock);
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_ir});
      check($sformatf("vec%0d_diff_hold", i), {31'd0, diff_hold}, {31'd0, tbl[i].exp_hold});
      tick;
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
      if (tbl[i].chk_data)
        check($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].exp_data});
    end
    check("count_after_stream", {16'd0, diff_count}, n_pushed);

    // Stop with a pending word: DRAIN holds it until taken, then IDLE.
    in_valid  = 1'b1;
    in_data   = 8'd5;
    out_ready = 1'b0;
    tick;
    check("pending_data", {24'd0, out_data}, 32'h83);
    enable  = 1'b0;
    in_data = 8'd9;
    @(negedge clock);
    check("enable_drop_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    check("drain_busy", {31'd0, busy}, 32'd1);
    check("drain_out_valid", {31'd0, out_valid}, 32'd1);
    tick;
    check("drain_hold_data", {24'd0, out_data}, 32'h83);
    check("drain_hold_busy", {31'd0, busy}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    check("drain_to_idle_busy", {31'd0, busy}, 32'd0);
    check("drain_to_idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Restart: 50 primes, 60 gives 10, count continues.
    start_run;
    in_valid = 1'b1;
    in_data  = 8'd50;
    tick;
    check("restart_prime_no_output", {31'd0, out_valid}, 32'd0);
    in_data = 8'd60;
    tick;
    check("restart_out_valid", {31'd0, out_valid}, 32'd1);
    check("restart_out_data", {24'd0, out_data}, 32'd10);
    check("restart_count", {16'd0, diff_count}, n_pushed);

    // Reset with a word pending.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    enable    = 1'b0;
    tick;
    check_reset_values("midrun");
    sb_q.delete();
    reset = 1'b0;

    // Signed overflow 0x7F -> 0x80, then a non-overflowing step.
    start_run;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h7F;
    tick;
    in_data = 8'h80;
    tick;
    check("ovf_out_data", {24'd0, out_data}, 32'h01);
    check("ovf_set", {31'd0, ovf}, {31'd0, OVF_EXP});
    in_data = 8'h81;
    tick;
    check("ovf_step_data", {24'd0, out_data}, 32'h01);
    check("ovf_sticky", {31'd0, ovf}, {31'd0, OVF_EXP});
    in_valid = 1'b0;
    enable   = 1'b0;
    tick;
    tick;
    tick;
    check("final_busy", {31'd0, busy}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
